uart_rx: RTL
============

# uart_rx

Serial receiver for the RS232 link: it oversamples the asynchronous `RS232_rx` line, recovers 8N1 frames at a fixed baud rate, and writes each valid byte into the write-side FIFO (wfifo) that feeds the rest of the design. It is the inbound counterpart of the transmit path, with the same clock, baud constants and FIFO handshake style.

## Interface
- `CLK_FREQ`, default 50_000_000: `sclk` frequency in Hz.
- `BAUD`, default 115200: line rate in bit/s.
- `sclk`  in  1  system clock, all logic on its rising edge.
- `reset`  in  1  synchronous, active-low reset, sampled on the `sclk` rising edge.
- `RS232_rx`  in  1  asynchronous serial input, idle high.
- `wfifo_full`  in  1  wfifo full flag.
- `wfifo_wr_en`  out  1  one-cycle wfifo write strobe.
- `wfifo_wr_data`  out  8  byte to write, valid while `wfifo_wr_en`=1.
- `rx_data`  out  8  last correctly framed byte, held until the next one.
- `rx_valid`  out  1  one-cycle pulse per correctly framed byte.
- `outflag_rx`  out  1  high while a frame is being received (states other than IDLE).
- `frame_err`  out  1  one-cycle pulse when the stop bit samples low.
- `overrun`  out  1  one-cycle pulse when a good byte is dropped because `wfifo_full`=1.

## Operation
- Constants: `BAUD_END` = `CLK_FREQ/BAUD - 1` (433 at the defaults); `HALF` = `BAUD_END/2` (216).
- `baud_cnt` is 13 bits wide, counts 0..`BAUD_END` and wraps to 0. It is held at 0 in IDLE.
- `RS232_rx` passes through a 2-FF synchronizer whose flops reset to 1. A falling edge is detected on the synchronized signal.
- FSM states and transitions:
  - IDLE: on a falling edge, go to START with `baud_cnt`=0.
  - START: when `baud_cnt`=`HALF`, check the line. If it is low, go to DATA and clear `baud_cnt`. If it is high, treat it as a glitch and return to IDLE.
  - DATA: sample at each `baud_cnt`=`BAUD_END`, which is the mid-bit point. Shift bits in LSB first and increment `bit_cnt` (4 bits). After the 8th sample, go to STOP.
  - STOP: sample at `baud_cnt`=`BAUD_END`, then go to IDLE in the next cycle.
    - Sample = 1: load `rx_data` and pulse `rx_valid`. If `wfifo_full`=0, also pulse `wfifo_wr_en` with `wfifo_wr_data`=byte. Otherwise pulse `overrun` and do not write.
    - Sample = 0: pulse `frame_err`. `rx_data` is unchanged and nothing is written.
- Returning to IDLE at the stop-bit midpoint allows back-to-back frames with no idle gap.
- Line held low (break): one `frame_err`, then IDLE. No new frame starts until the line goes high and then falls again.
- Reset (synchronous): state goes to IDLE, the counters clear, the synchronizer is set to 1, and all outputs go to 0. Reset mid-frame discards the partial byte with no pulse.

## Timing
- Synchronizer latency: 2 cycles.
- Falling edge detected at cycle E:
  - Start check at E+1+`HALF`.
  - Data bit k sampled at the start check + (k+1)·(`BAUD_END`+1).
  - Stop bit sampled at the start check + 9·(`BAUD_END`+1).
- `rx_valid`, `wfifo_wr_en`, `overrun` and `frame_err` are registered. They assert in the cycle after the stop sample and last exactly 1 cycle.
- `wfifo_full` is sampled in the same cycle as the stop sample.
- `outflag_rx` rises in the cycle after E and falls together with the result pulse.

## Configuration
- `UART_RX_MAJORITY_EN` defined: every START, DATA and STOP decision uses a 2-of-3 majority of the synchronized line at counts target-2, target-1 and target. The decision is still taken at the target count, so timing is identical.
- Not defined: a single sample at the target count.

## Structure
- Shared package `uart_pkg` holds:
  - `CLK_FREQ` and `BAUD` defaults and the `BAUD_END`/`HALF` functions, shared with the transmitter.
  - The state encoding: IDLE=0, START=1, DATA=2, STOP=3.
- Sub-module `uart_rx_sync`: 2-FF synchronizer plus falling-edge detector. Outputs are `rx_s` and `rx_fall`.

## Test plan
- Frame 0xA5 at 115200 baud, `wfifo_full`=0 -> one `rx_valid` and one `wfifo_wr_en`, with `wfifo_wr_data`=`rx_data`=0xA5, about 4125 cycles after the start edge.
- Low glitch of 100 cycles on an idle line -> returns to IDLE at the start check, no pulses, `outflag_rx` high for 217 cycles.
- Frame 0x3C with the stop bit forced low -> `frame_err` pulse, no `wfifo_wr_en`, `rx_data` keeps its previous value.
- Frame 0x81 with `wfifo_full`=1 -> `rx_valid` and `overrun` pulse, no `wfifo_wr_en`, `rx_data`=0x81.
- Back-to-back frames 0x00 then 0xFF with no idle gap -> two writes, 0x00 then 0xFF.
- `reset` asserted after data bit 3 of 0x55, then released -> all outputs are 0 and no pulse occurs; the next frame 0x12 is received correctly.
- With `UART_RX_MAJORITY_EN`: a one-cycle inverted spike at the mid-bit of bit 0 of 0xA5 -> still received as 0xA5.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants, baud-count helpers and receiver state encoding.
// Used by both the receive and transmit paths.
package uart_pkg;

  parameter int unsigned ClkFreqDefault = 50_000_000;
  parameter int unsigned BaudDefault    = 115200;
  parameter int unsigned BaudCntW       = 13;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } rx_state_e;

  // Last count of one bit period; the counter runs 0..baud_end and wraps.
  function automatic int unsigned baud_end(input int unsigned clk_freq, input int unsigned baud);
    return clk_freq / baud - 1;
  endfunction

  function automatic int unsigned half_cnt(input int unsigned clk_freq, input int unsigned baud);
    return baud_end(clk_freq, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Write-side FIFO handshake and receive status bundle of the UART receiver.
interface uart_rx_if;
  logic       wfifo_full;
  logic       wfifo_wr_en;
  logic [7:0] wfifo_wr_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       outflag_rx;
  logic       frame_err;
  logic       overrun;

  modport master (
    input  wfifo_full,
    output wfifo_wr_en,
    output wfifo_wr_data,
    output rx_data,
    output rx_valid,
    output outflag_rx,
    output frame_err,
    output overrun
  );

  modport slave (
    output wfifo_full,
    input  wfifo_wr_en,
    input  wfifo_wr_data,
    input  rx_data,
    input  rx_valid,
    input  outflag_rx,
    input  frame_err,
    input  overrun
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus falling-edge detect.
// Flops reset to the idle (high) level so reset never fakes a start edge.
module uart_rx_sync (
  input  logic sclk,
  input  logic reset,
  input  logic RS232_rx,
  output logic rx_s,
  output logic rx_fall
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge sclk) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= RS232_rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rx_s    = sync2_q;
  assign rx_fall = prev_q & ~sync2_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver writing good bytes into the wfifo. Optional macro
// UART_RX_MAJORITY_EN turns every line decision into a 2-of-3 vote.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = ClkFreqDefault,
  parameter int unsigned BAUD     = BaudDefault
) (
  input  logic      sclk,
  input  logic      reset,
  input  logic      RS232_rx,
  uart_rx_if.master rx_if
);

  localparam logic [BaudCntW-1:0] BaudEnd = BaudCntW'(baud_end(CLK_FREQ, BAUD));
  localparam logic [BaudCntW-1:0] Half    = BaudCntW'(half_cnt(CLK_FREQ, BAUD));

  logic rx_s;
  logic rx_fall;
  logic line_vote;

  uart_rx_sync u_sync (
    .sclk     (sclk),
    .reset    (reset),
    .RS232_rx (RS232_rx),
    .rx_s     (rx_s),
    .rx_fall  (rx_fall)
  );

`ifdef UART_RX_MAJORITY_EN
  // hist_q[0] is the line one cycle ago, hist_q[1] two cycles ago.
  logic [1:0] hist_q;

  always_ff @(posedge sclk) begin
    if (!reset) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], rx_s};
    end
  end

  assign line_vote = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign line_vote = rx_s;
`endif

  rx_state_e           state_q, state_d;
  logic [BaudCntW-1:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          shift_q, shift_d;
  logic [7:0]          rx_data_q, rx_data_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                wr_en_q, wr_en_d;
  logic                frame_err_q, frame_err_d;
  logic                overrun_q, overrun_d;

  logic                baud_wrap;
  logic [BaudCntW-1:0] baud_inc;

  assign baud_wrap = (baud_cnt_q == BaudEnd);
  assign baud_inc  = baud_wrap ? '0 : baud_cnt_q + BaudCntW'(1);

  always_ff @(posedge sclk) begin
    if (!reset) begin
      state_q     <= StIdle;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      wr_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      wr_data_q   <= wr_data_d;
      rx_valid_q  <= rx_valid_d;
      wr_en_q     <= wr_en_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = baud_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    wr_data_d   = wr_data_q;
    rx_valid_d  = 1'b0;
    wr_en_d     = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    case (state_q)
      StIdle: begin
        baud_cnt_d = '0;
        bit_cnt_d  = '0;
        if (rx_fall) begin
          state_d = StStart;
        end
      end

      StStart: begin
        baud_cnt_d = baud_inc;
        if (baud_cnt_q == Half) begin
          baud_cnt_d = '0;
          // A high line at the start midpoint was only a glitch.
          state_d    = line_vote ? StIdle : StData;
        end
      end

      StData: begin
        baud_cnt_d = baud_inc;
        if (baud_wrap) begin
          shift_d   = {line_vote, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            state_d = StStop;
          end
        end
      end

      StStop: begin
        baud_cnt_d = baud_inc;
        if (baud_wrap) begin
          // Leave at the stop midpoint so a following start edge is not missed.
          state_d    = StIdle;
          baud_cnt_d = '0;
          if (line_vote) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            if (!rx_if.wfifo_full) begin
              wr_en_d   = 1'b1;
              wr_data_d = shift_q;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign rx_if.wfifo_wr_en   = wr_en_q;
  assign rx_if.wfifo_wr_data = wr_data_q;
  assign rx_if.rx_data       = rx_data_q;
  assign rx_if.rx_valid      = rx_valid_q;
  assign rx_if.outflag_rx    = (state_q != StIdle);
  assign rx_if.frame_err     = frame_err_q;
  assign rx_if.overrun       = overrun_q;

endmodule
